// File: rtl/wb_port_arbiter.sv
// Two-requester register-file write-port arbiter: pipeline writeback (A) has fixed
// priority, long-latency writeback (B) is forced through after STARVE_LIMIT waits.
// Optional macro WB_PORT_FWD_EN exposes the registered write stage as fwd_* outputs.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        b_starved
`ifdef WB_PORT_FWD_EN
  ,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {NORMAL = 1'b0, FORCE_B = 1'b1} state_t;

  state_t     state_reg, state_next;
  logic [3:0] starve_cnt_reg, starve_cnt_next;
  logic       a_xfer, b_xfer;

  // Handshake depends only on state, a_valid and reset, never on b_valid or data.
  assign a_ready   = !rst && (state_reg == NORMAL);
  assign b_ready   = !rst && ((state_reg == FORCE_B) || !a_valid);
  assign a_xfer    = a_valid && a_ready;
  assign b_xfer    = b_valid && b_ready;
  assign b_starved = (state_reg == FORCE_B);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= NORMAL;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    if (!b_valid || b_xfer) begin
      starve_cnt_next = '0;
    end else begin
      starve_cnt_next = starve_cnt_reg + 4'd1;
    end
    case (state_reg)
      NORMAL: begin
        if (b_valid && !b_ready && (starve_cnt_reg + 4'd1 == LIMIT)) begin
          state_next = FORCE_B;
        end
      end
      FORCE_B: begin
        // A forced slot is never held open when B has nothing to write.
        if (b_xfer || !b_valid) begin
          state_next      = NORMAL;
          starve_cnt_next = '0;
        end
      end
      default: state_next = NORMAL;
    endcase
  end

  // Registered write stage; writes to x0 are accepted but never reach the file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= 1'b0;
      if (a_xfer) begin
        if (a_rd != 5'd0) begin
          rf_we    <= 1'b1;
          rf_waddr <= a_rd;
          rf_wdata <= a_data;
        end
      end else if (b_xfer) begin
        if (b_rd != 5'd0) begin
          rf_we    <= 1'b1;
          rf_waddr <= b_rd;
          rf_wdata <= b_data;
        end
      end
    end
  end

`ifdef WB_PORT_FWD_EN
  assign fwd_valid = rf_we;
  assign fwd_rd    = rf_waddr;
  assign fwd_data  = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected register-file writes are queued with
// their due cycle and a negedge monitor pops and compares each write it observes.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [4:0]  a_rd = '0;
  logic [31:0] a_data = '0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [4:0]  b_rd = '0;
  logic [31:0] b_data = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        b_starved;
`ifdef WB_PORT_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .b_starved(b_starved)
`ifdef WB_PORT_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bd);
    @(posedge clk);
    #1;
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // The write for a transfer issued in the current cycle must appear next cycle.
  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    wr_t w;
    w.rd = rd; w.data = data; w.cyc = cyc + 1;
    exp_q.push_back(w);
  endtask

  always @(negedge clk) begin
`ifdef WB_PORT_FWD_EN
    chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, rf_we});
    chk("fwd_rd", {27'd0, fwd_rd}, {27'd0, rf_waddr});
    chk("fwd_data", fwd_data, rf_wdata);
`endif
    if (!rst && rf_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: rd=%0d data=0x%0h, expected no write (cycle %0d)",
                 rf_waddr, rf_wdata, cyc);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_cycle", cyc, w.cyc);
        chk("wr_addr", {27'd0, rf_waddr}, {27'd0, w.rd});
        chk("wr_data", rf_wdata, w.data);
        $display("write rd=%0d data=0x%08h cycle=%0d", rf_waddr, rf_wdata, cyc);
      end
    end
  end

  initial begin
    #2;
    chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("reset_wdata", rf_wdata, 32'd0);
    chk("reset_starved", {31'd0, b_starved}, 32'd0);
    chk("reset_a_ready", {31'd0, a_ready}, 32'd0);
    chk("reset_b_ready", {31'd0, b_ready}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    idle();

    // A alone
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    chk("a_only_a_ready", {31'd0, a_ready}, 32'd1);
    chk("a_only_b_ready", {31'd0, b_ready}, 32'd0);
    expect_wr(5'd5, 32'hDEADBEEF);
    idle();
    chk("idle_b_ready", {31'd0, b_ready}, 32'd1);

    // Conflict: A first, B the cycle after
    drive(1'b1, 5'd3, 32'hAAAA0003, 1'b1, 5'd7, 32'hBBBB0007);
    chk("conf_b_ready", {31'd0, b_ready}, 32'd0);
    expect_wr(5'd3, 32'hAAAA0003);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hBBBB0007);
    chk("conf_b_ready2", {31'd0, b_ready}, 32'd1);
    expect_wr(5'd7, 32'hBBBB0007);
    idle();

    // Starvation: four A writes, one forced B write, then A resumes
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(10 + i), 32'h1000_0000 + 32'(i), 1'b1, 5'd9, 32'h9999_9999);
      chk("starve_a_ready", {31'd0, a_ready}, 32'd1);
      chk("starve_not_forced", {31'd0, b_starved}, 32'd0);
      expect_wr(5'(10 + i), 32'h1000_0000 + 32'(i));
    end
    drive(1'b1, 5'd14, 32'h1000_0004, 1'b1, 5'd9, 32'h9999_9999);
    chk("force_starved", {31'd0, b_starved}, 32'd1);
    chk("force_a_ready", {31'd0, a_ready}, 32'd0);
    chk("force_b_ready", {31'd0, b_ready}, 32'd1);
    expect_wr(5'd9, 32'h9999_9999);
    drive(1'b1, 5'd14, 32'h1000_0004, 1'b1, 5'd9, 32'h9999_9999);
    chk("resume_starved", {31'd0, b_starved}, 32'd0);
    chk("resume_a_ready", {31'd0, a_ready}, 32'd1);
    expect_wr(5'd14, 32'h1000_0004);
    idle();

    // Counter clears when b_valid drops: 3 waits, gap, 3 waits -> never forced
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 5'(16 + i), 32'h2000_0000 + 32'(i), (i != 3), 5'd8, 32'h8888_8888);
      chk("clear_not_forced", {31'd0, b_starved}, 32'd0);
      expect_wr(5'(16 + i), 32'h2000_0000 + 32'(i));
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h8888_8888);
    chk("clear_b_ready", {31'd0, b_ready}, 32'd1);
    expect_wr(5'd8, 32'h8888_8888);

    // Write to x0 is accepted but suppressed
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
    chk("x0_b_ready", {31'd0, b_ready}, 32'd1);
    idle();
    idle();

    // Asynchronous reset the cycle after an A transfer
    drive(1'b1, 5'd6, 32'hCAFE_F00D, 1'b0, 5'd0, 32'd0);
    @(posedge clk); #1;
    a_valid = 1'b0;
    chk("pre_rst_rf_we", {31'd0, rf_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
    chk("rst_starved", {31'd0, b_starved}, 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    idle();
    idle();
    drive(1'b1, 5'd2, 32'h0BAD_CAFE, 1'b0, 5'd0, 32'd0);
    expect_wr(5'd2, 32'h0BAD_CAFE);
    idle();
    idle();
    idle();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
